// File: rtl/conv_seq_pkg.sv
// Shared types for the conv layer sequencer: FSM state encoding and the
// output-channel index width helper.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_W    = 3'd2,
    RUN       = 3'd3,
    WRITE     = 3'd4,
    CLEAR     = 3'd5,
    CLEAR_ERR = 3'd6,
    DONE      = 3'd7
  } seq_state_t;

  // Never zero, so a single-channel layer still gets a 1-bit index port.
  function automatic int oc_idx_w(input int oc);
    return (oc > 1) ? $clog2(oc) : 1;
  endfunction

endpackage

// File: rtl/conv_layer_sequencer.sv
// Runs one binary conv layer channel by channel on a shared core: fetch weights,
// run the core under a watchdog, store the output map, then clear the core.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IC           = 8,
  parameter int OC           = 8,
  parameter int IMG_OUT_SIZE = 28,
  parameter int WA_W         = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [WA_W-1:0]                        wt_base,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic                                   wt_rd_en,
  output logic [WA_W-1:0]                        wt_addr,
  input  logic [IC*9-1:0]                        wt_rdata,
  output logic                                   core_en,
  output logic [IC*9-1:0]                        core_weights,
  input  logic                                   core_done,
  input  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]   core_img,
  output logic                                   fm_wr_en,
  output logic [oc_idx_w(OC)-1:0]                fm_wr_addr,
  output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]   fm_wr_data
);

  localparam int WW    = IC * 9;
  localparam int IMG_W = IMG_OUT_SIZE * IMG_OUT_SIZE;
  localparam int OC_W  = oc_idx_w(OC);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  seq_state_t       state_q, state_d;
  logic [WA_W-1:0]  base_q, base_d;
  logic [OC_W-1:0]  oc_q, oc_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wt_rd_en_q, wt_rd_en_d;
  logic [WA_W-1:0]  wt_addr_q, wt_addr_d;
  logic             core_en_q, core_en_d;
  logic [WW-1:0]    core_weights_q, core_weights_d;
  logic             fm_wr_en_q, fm_wr_en_d;
  logic [OC_W-1:0]  fm_wr_addr_q, fm_wr_addr_d;
  logic [IMG_W-1:0] fm_wr_data_q, fm_wr_data_d;

  logic             last_ch_s;
  logic             wdog_exp_s;

  assign last_ch_s  = (oc_q == OC_W'(OC - 1));
  assign wdog_exp_s = (wdog_q == WD_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; core_done outranks the watchdog in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = FETCH; else state_d = IDLE;
      FETCH:     state_d = WAIT_W;
      WAIT_W:    state_d = RUN;
      RUN: begin
        if (core_done)       state_d = WRITE;
        else if (wdog_exp_s) state_d = CLEAR_ERR;
        else                 state_d = RUN;
      end
      WRITE:     state_d = CLEAR;
      CLEAR:     if (last_ch_s) state_d = DONE; else state_d = FETCH;
      CLEAR_ERR: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: base/channel/watchdog bookkeeping, weight and map captures, sticky error
  always_comb begin
    base_d         = base_q;
    oc_d           = oc_q;
    wdog_d         = wdog_q;
    error_d        = error_q;
    core_weights_d = core_weights_q;
    fm_wr_data_d   = fm_wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = wt_base;
          oc_d    = '0;
          error_d = 1'b0;
        end else begin
          base_d  = base_q;
        end
      end
      WAIT_W: begin
        core_weights_d = wt_rdata;
        wdog_d         = '0;
      end
      RUN: begin
        wdog_d = wdog_q + WD_W'(1);
        if (core_done)       fm_wr_data_d = core_img;
        else if (wdog_exp_s) error_d      = 1'b1;
        else                 error_d      = error_q;
      end
      CLEAR: begin
        if (last_ch_s) oc_d = oc_q;
        else           oc_d = oc_q + OC_W'(1);
      end
      default: base_d = base_q;
    endcase
  end

  // Output decode from the upcoming state so every strobe leaves a flop aligned with its state
  always_comb begin
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
    wt_rd_en_d = (state_d == FETCH);
    core_en_d  = (state_d == RUN);
    fm_wr_en_d = (state_d == WRITE);
    if (state_d == FETCH) wt_addr_d = base_d + WA_W'(oc_d);
    else                  wt_addr_d = wt_addr_q;
    if (state_d == WRITE) fm_wr_addr_d = oc_q;
    else                  fm_wr_addr_d = fm_wr_addr_q;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q         <= '0;
      oc_q           <= '0;
      wdog_q         <= '0;
      error_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wt_rd_en_q     <= 1'b0;
      wt_addr_q      <= '0;
      core_en_q      <= 1'b0;
      core_weights_q <= '0;
      fm_wr_en_q     <= 1'b0;
      fm_wr_addr_q   <= '0;
      fm_wr_data_q   <= '0;
    end else begin
      base_q         <= base_d;
      oc_q           <= oc_d;
      wdog_q         <= wdog_d;
      error_q        <= error_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      wt_rd_en_q     <= wt_rd_en_d;
      wt_addr_q      <= wt_addr_d;
      core_en_q      <= core_en_d;
      core_weights_q <= core_weights_d;
      fm_wr_en_q     <= fm_wr_en_d;
      fm_wr_addr_q   <= fm_wr_addr_d;
      fm_wr_data_q   <= fm_wr_data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign wt_rd_en     = wt_rd_en_q;
  assign wt_addr      = wt_addr_q;
  assign core_en      = core_en_q;
  assign core_weights = core_weights_q;
  assign fm_wr_en     = fm_wr_en_q;
  assign fm_wr_addr   = fm_wr_addr_q;
  assign fm_wr_data   = fm_wr_data_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with a weight-memory model, a core model
// with per-channel done latency, and a per-cycle scoreboard.
module tb_conv_layer_sequencer;

  localparam int IC           = 8;
  localparam int OC           = 4;
  localparam int IMG_OUT_SIZE = 28;
  localparam int WA_W         = 8;
  localparam int TIMEOUT      = 64;
  localparam int WW           = IC * 9;
  localparam int IMG_W        = IMG_OUT_SIZE * IMG_OUT_SIZE;

  typedef logic [IMG_W-1:0] wide_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [WA_W-1:0]   wt_base = '0;
  logic              busy, done, error, wt_rd_en, core_en, fm_wr_en, core_done;
  logic [WA_W-1:0]   wt_addr;
  logic [WW-1:0]     wt_rdata = '0;
  logic [WW-1:0]     core_weights;
  logic [IMG_W-1:0]  core_img = '0;
  logic [1:0]        fm_wr_addr;
  logic [IMG_W-1:0]  fm_wr_data;

  always #5 clk = ~clk;

  conv_layer_sequencer #(
    .IC(IC), .OC(OC), .IMG_OUT_SIZE(IMG_OUT_SIZE), .WA_W(WA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .wt_base(wt_base),
    .busy(busy), .done(done), .error(error),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_rdata(wt_rdata),
    .core_en(core_en), .core_weights(core_weights), .core_done(core_done), .core_img(core_img),
    .fm_wr_en(fm_wr_en), .fm_wr_addr(fm_wr_addr), .fm_wr_data(fm_wr_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic wide_t img_pat(input int k);
    logic [7:0] b;
    b = 8'hA5 + 8'(k * 29);
    return {(IMG_W / 8){b}};
  endfunction

  // ---------------- weight memory model (1-cycle read latency) ----------------
  logic [WW-1:0] mem [0:255];

  task automatic fill_mem(input logic [WA_W-1:0] base);
    logic [WA_W-1:0] a;
    for (int i = 0; i < 256; i++) mem[i] = WW'({$urandom(), $urandom(), $urandom()}) | WW'(1);
    for (int k = 0; k < OC; k++) begin
      a = base + WA_W'(k);
      mem[a] = WW'(k * 32'h111);
    end
  endtask

  always @(posedge clk) if (wt_rd_en) wt_rdata <= mem[wt_addr];

  // ---------------- core model: done after dly[ch] enabled cycles (0 = never) ----------------
  int   dly [OC];
  int   chan = 0;
  int   en_cnt = 0;
  logic en_prev = 1'b0;
  logic core_done_m = 1'b0;
  logic inj_done = 1'b0;
  logic core_clr = 1'b0;

  assign core_done = core_done_m | inj_done;

  function automatic int chan_dly(input int c);
    return (c >= 0 && c < OC) ? dly[c] : 0;
  endfunction

  always @(posedge clk) begin
    en_prev <= core_en;
    if (rst || core_clr) begin
      chan <= 0; en_cnt <= 0; core_done_m <= 1'b0;
    end else if (core_en) begin
      en_cnt      <= en_cnt + 1;
      core_done_m <= (chan_dly(chan) != 0) && (en_cnt + 1 == chan_dly(chan));
      core_img    <= img_pat(chan);
    end else begin
      en_cnt <= 0; core_done_m <= 1'b0;
      if (en_prev) chan <= chan + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [WA_W-1:0] exp_addr_q[$];
  logic [WA_W-1:0] obs_addr[$];
  int exp_fm_k[$], obs_wr_cyc[$], obs_rd_cyc[$], obs_run[$], rel_q[$], rel1[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_en_cyc = 0, run_len = 0, sb_k;
  logic [WA_W-1:0] last_rd_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (wt_rd_en) begin
        obs_addr.push_back(wt_addr);
        obs_rd_cyc.push_back(cyc);
        last_rd_addr = wt_addr;
        chk("rd_busy", wide_t'(busy), wide_t'(1'b1));
        chk("rd_err_clear", wide_t'(error), wide_t'(1'b0));
        if (exp_addr_q.size() == 0) fail_now("rd_unexpected");
        else chk("wt_addr", wide_t'(wt_addr), wide_t'(exp_addr_q.pop_front()));
      end
      if (core_en) begin
        run_len++;
        last_en_cyc = cyc;
        chk("core_weights", wide_t'(core_weights), wide_t'(mem[last_rd_addr]));
      end else if (run_len != 0) begin
        obs_run.push_back(run_len);
        run_len = 0;
      end
      if (fm_wr_en) begin
        obs_wr_cyc.push_back(cyc);
        if (exp_fm_k.size() == 0) fail_now("fm_unexpected");
        else begin
          sb_k = exp_fm_k.pop_front();
          chk("fm_wr_addr", wide_t'(fm_wr_addr), wide_t'(sb_k));
          chk("fm_wr_data", fm_wr_data, img_pat(sb_k));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy", wide_t'(busy), wide_t'(1'b0));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  wide_t'(busy),  '0);
    chk({tag, "_done"},  wide_t'(done),  '0);
    chk({tag, "_error"}, wide_t'(error), '0);
    chk({tag, "_rd_en"}, wide_t'(wt_rd_en), '0);
    chk({tag, "_addr"},  wide_t'(wt_addr), '0);
    chk({tag, "_core_en"}, wide_t'(core_en), '0);
    chk({tag, "_weights"}, wide_t'(core_weights), '0);
    chk({tag, "_fm_en"}, wide_t'(fm_wr_en), '0);
    chk({tag, "_fm_addr"}, wide_t'(fm_wr_addr), '0);
    chk({tag, "_fm_data"}, fm_wr_data, '0);
  endtask

  // Clears core model and scoreboard, then loads expectations derived from dly[] and base.
  task automatic prep_layer(input logic [WA_W-1:0] base, output bit exp_err, output int n_ch);
    fill_mem(base);
    core_clr = 1'b1;
    @(negedge clk);
    core_clr = 1'b0;
    exp_addr_q.delete(); exp_fm_k.delete(); obs_addr.delete();
    obs_wr_cyc.delete(); obs_rd_cyc.delete(); obs_run.delete();
    run_len = 0;
    exp_err = 1'b0;
    n_ch    = 0;
    for (int k = 0; k < OC; k++) begin
      if (!exp_err) begin
        exp_addr_q.push_back(base + WA_W'(k));
        n_ch++;
        if (dly[k] == 0) exp_err = 1'b1;
        else exp_fm_k.push_back(k);
      end
    end
  endtask

  task automatic run_layer(input logic [WA_W-1:0] base, input bit inject);
    bit exp_err, got;
    int n_ch, d0, s_cyc, exp_run;
    prep_layer(base, exp_err, n_ch);
    d0      = done_cnt;
    wt_base = base;
    start   = 1'b1;
    s_cyc   = cyc;
    got     = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk); #1;
      start    = inject && core_en && (run_len == 3);
      inj_done = inject && wt_rd_en;
      got      = (done_cnt != d0);
    end
    start = 1'b0;
    inj_done = 1'b0;
    if (!got) fail_now("done_timeout");
    repeat (3) @(negedge clk);
    #1;
    chk("done_count", wide_t'(done_cnt - d0), wide_t'(1));
    chk("error_end", wide_t'(error), wide_t'(exp_err));
    chk("rd_left", wide_t'(exp_addr_q.size()), '0);
    chk("fm_left", wide_t'(exp_fm_k.size()), '0);
    chk("run_count", wide_t'(obs_run.size()), wide_t'(n_ch));
    if (obs_rd_cyc.size() > 0) chk("start_to_fetch", wide_t'(obs_rd_cyc[0] - s_cyc), wide_t'(1));
    for (int k = 0; k < obs_run.size(); k++) begin
      exp_run = (dly[k] == 0) ? TIMEOUT : dly[k] + 1;
      chk("run_len", wide_t'(obs_run[k]), wide_t'(exp_run));
    end
    for (int i = 1; i < obs_wr_cyc.size(); i++)
      chk("fm_spacing", wide_t'(obs_wr_cyc[i] - obs_wr_cyc[i-1]), wide_t'(dly[i] + 5));
    if (!exp_err && obs_wr_cyc.size() > 0)
      chk("done_after_wr", wide_t'(done_cyc - obs_wr_cyc[obs_wr_cyc.size()-1]), wide_t'(2));
    else
      chk("done_after_run", wide_t'(done_cyc - last_en_cyc), wide_t'(2));
    rel_q.delete();
    foreach (obs_wr_cyc[i]) rel_q.push_back(obs_wr_cyc[i] - s_cyc);
  endtask

  logic [WA_W-1:0] s1_addr [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [WA_W-1:0] s6_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    bit e;
    int n, d0;
    bit got;
    for (int k = 0; k < OC; k++) dly[k] = IC + 1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Plain layer, base 0x10
    run_layer(8'h10, 1'b0);
    chk("s1_n_addr", wide_t'(obs_addr.size()), wide_t'(4));
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("s1_addr", wide_t'(obs_addr[i]), wide_t'(s1_addr[i]));
    chk("s1_n_wr", wide_t'(obs_wr_cyc.size()), wide_t'(4));
    for (int i = 1; i < obs_wr_cyc.size(); i++) chk("s1_spacing", wide_t'(obs_wr_cyc[i] - obs_wr_cyc[i-1]), wide_t'(14));
    rel1 = rel_q;

    // Stray start in RUN and core_done in FETCH must not disturb the sequence
    run_layer(8'h10, 1'b1);
    chk("s4_n_wr", wide_t'(rel_q.size()), wide_t'(rel1.size()));
    for (int i = 0; i < rel1.size() && i < rel_q.size(); i++) chk("s4_same_timing", wide_t'(rel_q[i]), wide_t'(rel1[i]));

    // Core never finishes channel 2
    dly[2] = 0;
    run_layer(8'h10, 1'b0);
    chk("s3_n_wr", wide_t'(obs_wr_cyc.size()), wide_t'(2));
    if (obs_run.size() > 2) chk("s3_run64", wide_t'(obs_run[2]), wide_t'(64));
    else fail_now("s3_run64");
    chk("s3_error", wide_t'(error), wide_t'(1'b1));
    dly[2] = IC + 1;

    // Reset during RUN of channel 1
    prep_layer(8'h10, e, n);
    d0 = done_cnt;
    wt_base = 8'h10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk); #1;
      got = core_en && (obs_wr_cyc.size() == 1);
    end
    if (!got) fail_now("s5_reach_ch1");
    rst = 1'b1;
    @(negedge clk); #1;
    chk_zero("mid_rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("s5_no_done", wide_t'(done_cnt - d0), '0);
    chk("s5_idle", wide_t'(busy), '0);
    run_layer(8'h10, 1'b0);
    chk("s5_n_wr", wide_t'(obs_wr_cyc.size()), wide_t'(4));

    // Address wrap, and core_done landing on the last watchdog cycle
    dly[0] = TIMEOUT - 1;
    run_layer(8'hFE, 1'b0);
    chk("s6_n_addr", wide_t'(obs_addr.size()), wide_t'(4));
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("s6_addr", wide_t'(obs_addr[i]), wide_t'(s6_addr[i]));
    if (obs_run.size() > 0) chk("s6_run64", wide_t'(obs_run[0]), wide_t'(64));
    else fail_now("s6_run64");
    chk("s6_n_wr", wide_t'(obs_wr_cyc.size()), wide_t'(4));
    chk("s6_error", wide_t'(error), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
